// File: rtl/slice_mem_ctrl.sv
// slice_mem_ctrl: counts pixels/windows/rows for the slice_mem bank, gates dvi,
// and sequences the drain, download and clear that follow each frame.
module slice_mem_ctrl #(
    parameter int BLOCKSIZE = 8,
    parameter int WPI       = 32,
    parameter int WINROWS   = 16,
    parameter int DRAIN     = 2,
    localparam int WW       = $clog2(WPI)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_dvi,
    output logic          o_ready,
    output logic          o_dvi_mem,
    output logic          o_newwin,
    output logic          o_download,
    output logic          o_clr,
    output logic          o_dvo,
    output logic [WW-1:0] o_win_idx,
    output logic          o_frame_done,
    output logic          o_overrun
);
    localparam int BW = $clog2(BLOCKSIZE);
    localparam int RW = WINROWS > 1 ? $clog2(WINROWS) : 1;
    localparam int DW = DRAIN > 1 ? $clog2(DRAIN) : 1;
    localparam logic [BW-1:0] B_MAX = BW'(BLOCKSIZE - 1);
    localparam logic [WW-1:0] W_MAX = WW'(WPI - 1);
    localparam logic [RW-1:0] R_MAX = RW'(WINROWS - 1);
    localparam logic [DW-1:0] D_MAX = DW'(DRAIN - 1);

    typedef enum logic [1:0] {OP, WAIT, DOWNLOAD, CLR} state_t;

    state_t        r_state;
    logic [BW-1:0] r_dvcount;
    logic [WW-1:0] r_wincount;
    logic [RW-1:0] r_rowcount;
    logic [DW-1:0] r_drain;
    logic [WW-1:0] r_win_idx;
    logic          r_dvo;
    logic          r_overrun;
    logic          w_op;
    logic          w_dvi_mem;
    logic          w_done;

    assign w_op         = r_state == OP;
    assign w_dvi_mem    = i_dvi & w_op;
    assign w_done       = w_dvi_mem & (r_dvcount == B_MAX) & (r_wincount == W_MAX) & (r_rowcount == R_MAX);
    assign o_ready      = w_op;
    assign o_dvi_mem    = w_dvi_mem;
    assign o_newwin     = (w_op & (r_dvcount == B_MAX)) | (r_state == DOWNLOAD);
    assign o_download   = r_state == DOWNLOAD;
    assign o_clr        = r_state == CLR;
    assign o_dvo        = r_dvo;
    assign o_win_idx    = r_win_idx;
    assign o_frame_done = w_done;
    // A dropped pixel is flagged in the very cycle it is offered, then held.
    assign o_overrun    = r_overrun | (i_dvi & ~w_op);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= OP;
            r_dvcount  <= '0;
            r_wincount <= '0;
            r_rowcount <= '0;
            r_drain    <= '0;
            r_win_idx  <= '0;
            r_dvo      <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_dvo <= r_state == DOWNLOAD;
            if (r_state == DOWNLOAD) r_win_idx <= r_wincount;
            if (i_dvi & ~w_op) r_overrun <= 1'b1;
            case (r_state)
                OP: begin
                    if (w_dvi_mem) begin
                        if (r_dvcount == B_MAX) begin
                            r_dvcount <= '0;
                            if (r_wincount == W_MAX) begin
                                r_wincount <= '0;
                                if (r_rowcount == R_MAX) begin
                                    r_rowcount <= '0;
                                    r_state    <= WAIT;
                                end else r_rowcount <= r_rowcount + 1'b1;
                            end else r_wincount <= r_wincount + 1'b1;
                        end else r_dvcount <= r_dvcount + 1'b1;
                    end
                end
                WAIT: begin
                    if (r_drain == D_MAX) begin
                        r_drain <= '0;
                        r_state <= DOWNLOAD;
                    end else r_drain <= r_drain + 1'b1;
                end
                DOWNLOAD: begin
                    if (r_wincount == W_MAX) begin
                        r_wincount <= '0;
                        r_state    <= CLR;
                    end else r_wincount <= r_wincount + 1'b1;
                end
                CLR: begin
                    r_wincount <= '0;
                    r_state    <= OP;
                end
                default: r_state <= OP;
            endcase
        end
    end
endmodule

// File: tb/tb_slice_mem_ctrl.sv
// tb_slice_mem_ctrl: default and corner-parameter controllers driven by shared
// stimulus, each checked every cycle against a pixel-index/dead-time model.
module tb_slice_mem_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic dvi = 1'b0;
    int tb_checks = 0;
    int tb_errs = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : c
        localparam int BS = g == 0 ? 8 : 2;
        localparam int WP = g == 0 ? 32 : 2;
        localparam int WR = g == 0 ? 16 : 1;
        localparam int DR = g == 0 ? 2 : 1;
        localparam int FRAME = BS * WP * WR;
        localparam int DEAD = DR + WP + 1;
        localparam int LIT_FRAME = g == 0 ? 4096 : 4;
        localparam int LIT_NW = g == 0 ? 512 : 2;
        localparam int LIT_DEAD = g == 0 ? 35 : 4;
        localparam int LIT_GAP = g == 0 ? 4 : 3;
        localparam int LIT_DL = g == 0 ? 32 : 2;

        logic ready, dvi_mem, newwin, download, clr, dvo, frame_done, overrun;
        logic [$clog2(WP)-1:0] win_idx;

        slice_mem_ctrl #(.BLOCKSIZE(BS), .WPI(WP), .WINROWS(WR), .DRAIN(DR)) dut (
            .i_clk(clk), .i_reset_n(reset_n), .i_dvi(dvi),
            .o_ready(ready), .o_dvi_mem(dvi_mem), .o_newwin(newwin),
            .o_download(download), .o_clr(clr), .o_dvo(dvo), .o_win_idx(win_idx),
            .o_frame_done(frame_done), .o_overrun(overrun)
        );

        int checks = 0, errs = 0, frames = 0;
        int p = 0, t = 0, widx = 0;
        bit sticky = 1'b0;
        int acc = 0, nw = 0, dead = 0, dl_n = 0, dv_n = 0, gap = 0;
        bit armed = 1'b0, seen = 1'b0;

        task automatic chk(input string name, input int act, input int exp);
            checks++;
            if (act != exp) begin
                errs++;
                $display("FAIL %s cfg%0d @%0t got %0d expected %0d", name, g, $time, act, exp);
            end
        endtask

        // t==0 while accepting; otherwise cycles elapsed since the last pixel of a frame
        always @(negedge clk) if (reset_n) begin
            bit rdy, dl, dv;
            int wi;
            rdy = t == 0;
            dl  = t >= DR + 1 && t <= DR + WP;
            dv  = t >= DR + 2 && t <= DR + WP + 1;
            wi  = dv ? t - DR - 2 : widx;
            chk("ready", int'(ready), int'(rdy));
            chk("dvi_mem", int'(dvi_mem), int'(rdy && dvi));
            chk("newwin", int'(newwin), int'((rdy && p % BS == BS - 1) || dl));
            chk("download", int'(download), int'(dl));
            chk("clr", int'(clr), int'(t == DEAD));
            chk("dvo", int'(dvo), int'(dv));
            chk("win_idx", int'(win_idx), wi);
            chk("frame_done", int'(frame_done), int'(rdy && dvi && p == FRAME - 1));
            chk("overrun", int'(overrun), int'(sticky || (dvi && !rdy)));
        end

        always @(posedge clk) begin
            if (!reset_n) begin
                p = 0; t = 0; sticky = 1'b0; widx = 0;
            end else begin
                if (t >= DR + 2 && t <= DR + WP + 1) widx = t - DR - 2;
                if (dvi && t != 0) sticky = 1'b1;
                if (t == 0) begin
                    if (dvi) begin
                        if (p == FRAME - 1) begin p = 0; t = 1; end
                        else p++;
                    end
                end else t = (t == DEAD) ? 0 : t + 1;
            end
        end

        // Frame-level measurements against hand-computed figures.
        always @(negedge clk) begin
            if (!reset_n) begin
                acc = 0; nw = 0; armed = 1'b0;
            end else begin
                if (dvi_mem) acc++;
                if (newwin && dvi_mem) nw++;
                if (frame_done) begin
                    chk("frame_len", acc, LIT_FRAME);
                    chk("newwin_cnt", nw, LIT_NW);
                    frames++;
                    acc = 0; nw = 0; armed = 1'b1; seen = 1'b0;
                    dead = 0; dl_n = 0; dv_n = 0; gap = 0;
                end else if (armed) begin
                    gap++;
                    if (!ready) dead++;
                    if (download) dl_n++;
                    if (dvo) begin
                        if (!seen) chk("dvo_gap", gap, LIT_GAP);
                        seen = 1'b1;
                        dv_n++;
                    end
                    if (clr) begin
                        chk("clr_dvo", int'(dvo), 1);
                        chk("clr_widx", int'(win_idx), LIT_DL - 1);
                    end
                    if (ready) begin
                        chk("dead_cycles", dead, LIT_DEAD);
                        chk("download_cnt", dl_n, LIT_DL);
                        chk("dvo_cnt", dv_n, LIT_DL);
                        armed = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tchk(input string name, input int act, input int exp);
        tb_checks++;
        if (act != exp) begin
            tb_errs++;
            $display("FAIL %s @%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    // mode 0: dvi=1, mode 1: random 50%
    task automatic run_frames(input int nfr, input int mode, input int bound, input string name);
        int start;
        bit ok;
        start = c[0].frames;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (c[0].frames >= start + nfr) begin ok = 1'b1; break; end
            dvi = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
        tchk(name, int'(ok), 1);
    endtask

    initial begin
        int n;
        bit found;
        dvi = 1'b0;
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        tchk("rst_ready", int'(c[0].ready), 1);
        tchk("rst_dvo", int'(c[0].dvo), 0);
        tchk("rst_win_idx", int'(c[0].win_idx), 0);
        tchk("rst_overrun", int'(c[0].overrun), 0);
        tchk("rst_clr", int'(c[0].clr), 0);
        tchk("rst_download", int'(c[0].download), 0);
        tchk("rst_frame_done", int'(c[0].frame_done), 0);
        tchk("rst_ready_c1", int'(c[1].ready), 1);

        // dvi follows ready: a full frame with no dropped pixel
        for (int i = 0; i < 4300; i++) begin
            dvi = c[0].ready;
            step();
        end
        tchk("no_overrun", int'(c[0].overrun), 0);
        tchk("frame1_seen", int'(c[0].frames >= 1), 1);

        pulse_reset();
        run_frames(3, 1, 40000, "random_frames");

        run_frames(1, 0, 5000, "held_frame");
        repeat (40) step();
        tchk("overrun_sticky", int'(c[0].overrun), 1);

        pulse_reset();
        dvi = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (c[0].download) n++;
            if (n == 10) begin found = 1'b1; break; end
            step();
        end
        tchk("reach_dl10", int'(found), 1);
        pulse_reset();
        tchk("post_rst_dvo", int'(c[0].dvo), 0);
        tchk("post_rst_ready", int'(c[0].ready), 1);
        tchk("post_rst_download", int'(c[0].download), 0);
        run_frames(1, 0, 5000, "after_reset_frame");
        dvi = 1'b0;
        repeat (40) step();

        for (int i = 0; i < 300; i++) begin
            dvi = 1'($urandom_range(0, 1));
            step();
        end
        dvi = 1'b0;
        repeat (1000) step();
        dvi = 1'b1;
        repeat (500) step();
        dvi = 1'b0;
        step();
        tchk("frames_total", int'(c[0].frames >= 6), 1);

        $display("CHECKS %0d ERRORS %0d", tb_checks + c[0].checks + c[1].checks,
                 tb_errs + c[0].errs + c[1].errs);
        $finish;
    end
endmodule

// File: doc/slice_mem_ctrl.md
# slice_mem_ctrl

Sequencing controller for the `slice_mem` accumulator bank. It counts accepted pixels per block, windows per row and rows per frame, and gates `dvi` into the datapath. It drives `newwin` and `download` to the bank and emits a registered download-valid with the window index. A frame is `WINROWS` rows × `WPI` windows × `BLOCKSIZE` pixels; after the last accepted pixel it drains, downloads all `WPI` accumulators, clears, and resumes accepting pixels.

## Interface
- `BLOCKSIZE`, 8: pixels per window per row (≥2).
- `WPI`, 32: windows per image row = accumulators in `slice_mem` (≥2).
- `WINROWS`, 16: rows per window frame (≥1).
- `DRAIN`, 2: idle cycles between last accepted pixel and first `download` cycle (≥1); covers the datapath MAC latency.
- `clk`, input, 1: single clock; all logic on rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `dvi`, input, 1: upstream pixel valid.
- `ready`, output, 1: high only in OP; pixels offered while low are dropped.
- `dvi_mem`, output, 1: `dvi & ready`, to `slice_mem.dvi`.
- `newwin`, output, 1: to `slice_mem.newwin`.
- `download`, output, 1: to `slice_mem.download`.
- `clr`, output, 1: one-cycle pulse; frame complete, accumulators cleared.
- `dvo`, output, 1: `slice_mem.regout` valid this cycle.
- `win_idx`, output, clog2(WPI): window index of the `regout` word qualified by `dvo`.
- `frame_done`, output, 1: one-cycle pulse on the cycle the last pixel of a frame is accepted.
- `overrun`, output, 1: sticky; set when `dvi=1` while `ready=0`; cleared only by reset.

## Operation
- **Counters:** `dvcount` (0..BLOCKSIZE-1), `wincount` (0..WPI-1), `rowcount` (0..WINROWS-1).
  - `dvcount` advances on `dvi_mem` and wraps at BLOCKSIZE-1, which also advances `wincount`.
  - `wincount` wrapping at WPI-1 advances `rowcount`.
- **End of frame:** `done` = `dvi_mem` & all three counters at max. It zeroes all counters and asserts `frame_done`.
- **States:**
  - OP → WAIT on `done`.
  - WAIT holds DRAIN cycles (internal counter), then → DOWNLOAD.
  - DOWNLOAD lasts exactly WPI cycles; `wincount` increments each cycle, and the state → CLR when `wincount==WPI-1`.
  - CLR holds one cycle, zeroes `wincount`, then → OP.
  - Illegal encodings → OP.
- **Outputs per state:**
  - `ready` = (state==OP).
  - `newwin` = (state==OP & `dvcount`==BLOCKSIZE-1) | (state==DOWNLOAD). It is a level; `slice_mem` qualifies it with `dvi`/`download`.
  - `download` = (state==DOWNLOAD).
  - `clr` = (state==CLR).
- **Download outputs:** `dvo` is `download` registered one cycle. `win_idx` is `wincount` registered under the same condition, holding its value otherwise.
- **Reset values:** all counters 0, state OP. Outputs: `dvo`=0, `win_idx`=0, `overrun`=0, `frame_done`=0, `clr`=0, `download`=0, `ready`=1.
- **Reset mid-frame or mid-download:** abandons the frame; no further `dvo` after the reset edge. Accumulator contents are the datapath's concern.
- **Dropped pixels:** `dvi` in WAIT, DOWNLOAD or CLR does not touch the counters and sets `overrun`.
- **Partial row:** if `dvi` stalls, the counters hold indefinitely; there is no timeout.

## Timing
- `ready`, `dvi_mem`, `newwin`, `download` and `clr` are combinational from state/counters. `dvi_mem` is additionally combinational from `dvi`.
- Cycle N accepts the last pixel. Then:
  - `ready`=0 from N+1.
  - WAIT covers N+1..N+DRAIN.
  - `download` is high on N+DRAIN+1..N+DRAIN+WPI.
  - `dvo` is high on N+DRAIN+2..N+DRAIN+WPI+1, with `win_idx` = 0..WPI-1 in order.
  - `clr` is high on N+DRAIN+WPI+1.
  - `ready`=1 again on N+DRAIN+WPI+2.
- Dead time per frame: DRAIN+WPI+1 cycles.
- `dvo` of the last window coincides with `clr`. A pixel at N+DRAIN+WPI+2 is accepted as frame pixel 0, window 0.

## Test plan
1. **Reset, then continuous `dvi`=1, defaults:** `frame_done` on the 4096th accepted pixel. `dvo` asserts 32 cycles with `win_idx` 0..31 starting 4 cycles after `frame_done`. `clr` on the cycle of `win_idx`=31. `overrun`=0 if `dvi` drops when `ready`=0.
2. **Random `dvi` (50%), self-check model:** per-window sum of data×svcoeff matches `regout` at every `dvo` across 3 frames. `newwin` pulses exactly 512 times (16×32) per frame in OP.
3. **`dvi` held 1 through WAIT/DOWNLOAD:** `overrun` sets on N+1 and stays 1. Counters are unchanged: the first pixel after `clr` is counted as `dvcount` 0.
4. **Reset asserted on 10th DOWNLOAD cycle:** the next cycle has `dvo`=0, state OP, `ready`=1, all counters 0. The next frame completes normally with 32 `dvo`.
5. **Corner parameters BLOCKSIZE=2, WPI=2, WINROWS=1, DRAIN=1:**
   - `frame_done` after 4 pixels.
   - `download` high 2 cycles.
   - `dvo`/`win_idx` = 0,1.
   - 4 dead cycles.
6. **`dvi` stalled mid-row for 1000 cycles:** no state change, no `newwin` in the stall. Counting resumes exactly where it stopped.
